frame_config_sequencer: RTL and testbench
=========================================

Name: frame_config_sequencer

Overview:
- Sequences configuration-frame writes into the fabric's FrameData/FrameStrobe distribution network.
- Accepts a 32-bit word stream, for example from the USB bitstream path. Each frame packet has one header word followed by NumRows data words.
- Each data word is broadcast on frame_data_o and latched into a row's frame register using a one-hot row write-enable.
- The selected column's FrameStrobe bit is then pulsed once, which commits the frame into the tiles' config latches.

Parameters:
- FrameBitsPerRow, 32: frame data word width. The header format requires 32.
- MaxFramesPerCol, 20: width of frame_strobe_o.
- NumRows, 16: data words per frame, and width of row_we_o.
- NumColumns, 16: number of legal column indices.
- ColBits, 8: width of col_sel_o.

Ports:
- UserCLK  input  1  clock.
- resetn  input  1  synchronous active-low reset.
- in_data  input  FrameBitsPerRow  stream word.
- in_valid  input  1  stream word valid.
- in_ready  output  1  sequencer accepts word this cycle.
- frame_data_o  output  FrameBitsPerRow  word broadcast to row frame registers.
- row_we_o  output  NumRows  one-hot, one-cycle row latch enable.
- col_sel_o  output  ColBits  column targeted by frame_strobe_o.
- frame_strobe_o  output  MaxFramesPerCol  one-hot, one-cycle frame commit strobe.
- busy  output  1  high whenever state is not IDLE.
- cfg_error  output  1  sticky error flag.
- frames_done  output  16  count of committed frames.

Behaviour:
- Interface: one clock, UserCLK. Reset resetn is synchronous and active-low.
- Reset values (all outputs registered): in_ready=0 during reset and 1 the cycle after; frame_data_o=0; row_we_o=0; col_sel_o=0; frame_strobe_o=0; busy=0; cfg_error=0; frames_done=0; state=IDLE.
- Handshake: a word transfers on in_valid && in_ready. in_ready=1 in IDLE and DATA, 0 in STROBE and GAP. in_data must hold stable while in_valid && !in_ready.
- Header word layout:
  - [31:28] opcode; 4'hA = frame write.
  - [27:20] column.
  - [19:12] frame index.
  - [11:0] ignored.
- IDLE: on header transfer, validate it.
  - Invalid if opcode != 4'hA, column >= NumColumns, or frame >= MaxFramesPerCol.
  - Invalid header: set cfg_error, drop the word, stay in IDLE.
  - Valid header: latch column and frame, clear row_cnt, go to DATA.
- DATA: each transfer produces, on the next cycle:
  - frame_data_o = word;
  - row_we_o = 1<<row_cnt for exactly one cycle;
  - row_cnt increments.
  - After transfer number NumRows (row_cnt == NumRows-1), go to STROBE.
  - Stalls (in_valid=0) just hold state; row_we_o stays 0.
- STROBE (1 cycle):
  - col_sel_o = latched column;
  - frame_strobe_o = 1<<frame;
  - frames_done increments and saturates at 16'hFFFF.
  - frame_data_o holds the last row word. The last row_we pulse and the strobe fall in consecutive cycles; they are never simultaneous.
- GAP (1 cycle): frame_strobe_o = 0, col_sel_o holds, then return to IDLE. Minimum packet-to-packet spacing is therefore 2 idle cycles.
- Latency: header to first possible row_we is 2 cycles. Last data transfer to frame_strobe_o is 2 cycles.
- cfg_error clears only on reset.
- Reset mid-operation: abort immediately. No further row_we or strobe is issued, and a partially loaded frame is never committed.
- row_we_o and frame_strobe_o are never asserted in the same cycle and are never more than one-hot.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- When defined:
  - Each packet carries one extra trailing word after the NumRows data words. It must equal the XOR of those data words.
  - New state CHECK accepts this word (in_ready=1).
  - On match: STROBE as normal.
  - On mismatch: set cfg_error, skip STROBE, go to GAP; frames_done unchanged. Row registers keep the loaded data, but it is uncommitted.
- When undefined: no trailing word, no XOR register; DATA goes directly to STROBE.

Decomposition:
- Shared package frame_cfg_pkg holds:
  - state enum (IDLE, DATA, CHECK, STROBE, GAP);
  - OPC_FRAME_WRITE = 4'hA;
  - header field bit positions;
  - FRAMES_DONE_W = 16.
- One natural sub-module, frame_hdr_decode: combinational header field extraction plus the validity check against NumColumns and MaxFramesPerCol.

Test Plan (all with NumRows overridden to 4):
- Reset release, then header 32'hA_03_05_000 and data 1,2,3,4 with in_valid held high. Expect:
  - row_we_o = 1,2,4,8 on consecutive cycles, with frame_data_o = 1,2,3,4;
  - then frame_strobe_o = 20'h00020 with col_sel_o = 3 for 1 cycle;
  - frames_done = 1.
- Bad headers: 32'hB_00_00_000, then column 16, then frame 20. Expect cfg_error = 1, no row_we_o or strobe, state stays IDLE. A following valid packet still commits.
- in_valid toggling 1/0 throughout a packet: the row_we sequence is unchanged, with one pulse per transfer and none during stalls. The strobe appears 2 cycles after the 4th transfer.
- resetn asserted after 2 data words: no further row_we_o and no strobe; all outputs 0 next cycle. A new full packet commits normally.
- FRAME_CHECKSUM_EN, data 1,2,3,4:
  - trailer 4 → strobe asserted;
  - trailer 5 → cfg_error = 1, no strobe, frames_done unchanged.
- Back-to-back packets: in_ready stays low exactly 2 cycles (STROBE, GAP) between the last data word and the next header acceptance.

Source files
------------

// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared types and header field layout for the frame config sequencer
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CHECK,
    STROBE,
    GAP
  } state_e;

  localparam logic [3:0] OPC_FRAME_WRITE = 4'hA;

  localparam int HDR_OPC_HI = 31;
  localparam int HDR_OPC_LO = 28;
  localparam int HDR_COL_HI = 27;
  localparam int HDR_COL_LO = 20;
  localparam int HDR_FRM_HI = 19;
  localparam int HDR_FRM_LO = 12;

  // Only bits [31:12] of a header carry information.
  localparam int HDR_W       = HDR_OPC_HI - HDR_FRM_LO + 1;
  localparam int HDR_FIELD_W = HDR_COL_HI - HDR_COL_LO + 1;

  localparam int FRAMES_DONE_W = 16;

endpackage

// File: rtl/frame_hdr_decode.sv
// rtl/frame_hdr_decode.sv - header field extraction and range check
module frame_hdr_decode
  import frame_cfg_pkg::*;
#(
  parameter int NumColumns      = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [HDR_W-1:0]       hdr,
  output logic [HDR_FIELD_W-1:0] column,
  output logic [HDR_FIELD_W-1:0] frame,
  output logic                   valid
);

  logic [3:0] opcode;

  assign opcode = hdr[HDR_OPC_HI-HDR_FRM_LO : HDR_OPC_LO-HDR_FRM_LO];
  assign column = hdr[HDR_COL_HI-HDR_FRM_LO : HDR_COL_LO-HDR_FRM_LO];
  assign frame  = hdr[HDR_FRM_HI-HDR_FRM_LO : 0];

  assign valid = (opcode == OPC_FRAME_WRITE)
              && ({24'd0, column} < 32'(NumColumns))
              && ({24'd0, frame} < 32'(MaxFramesPerCol));

endmodule

// File: rtl/frame_config_sequencer.sv
// rtl/frame_config_sequencer.sv - sequences frame packets into row latch enables and a column frame strobe
// Define FRAME_CHECKSUM_EN to require a trailing XOR checksum word per packet.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 16,
  parameter int ColBits         = 8
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] frame_data_o,
  output logic [NumRows-1:0]         row_we_o,
  output logic [ColBits-1:0]         col_sel_o,
  output logic [MaxFramesPerCol-1:0] frame_strobe_o,
  output logic                       busy,
  output logic                       cfg_error,
  output logic [FRAMES_DONE_W-1:0]   frames_done
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_e                 state;
  logic [RowW-1:0]        row_cnt;
  logic [HDR_FIELD_W-1:0] col_q;
  logic [HDR_FIELD_W-1:0] frm_q;
  logic [HDR_FIELD_W-1:0] hdr_col;
  logic [HDR_FIELD_W-1:0] hdr_frm;
  logic                   hdr_ok;
  logic                   xfer;
`ifdef FRAME_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] xor_acc;
`endif

  assign xfer = in_valid && in_ready;

  frame_hdr_decode #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_hdr_decode (
    .hdr    (in_data[HDR_OPC_HI:HDR_FRM_LO]),
    .column (hdr_col),
    .frame  (hdr_frm),
    .valid  (hdr_ok)
  );

  // in_ready and busy are registered alongside state so they track it exactly.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state          <= IDLE;
      row_cnt        <= '0;
      col_q          <= '0;
      frm_q          <= '0;
      in_ready       <= 1'b0;
      frame_data_o   <= '0;
      row_we_o       <= '0;
      col_sel_o      <= '0;
      frame_strobe_o <= '0;
      busy           <= 1'b0;
      cfg_error      <= 1'b0;
      frames_done    <= '0;
`ifdef FRAME_CHECKSUM_EN
      xor_acc        <= '0;
`endif
    end else begin
      row_we_o       <= '0;
      frame_strobe_o <= '0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (xfer) begin
            if (hdr_ok) begin
              col_q   <= hdr_col;
              frm_q   <= hdr_frm;
              row_cnt <= '0;
              state   <= DATA;
              busy    <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
              xor_acc <= '0;
`endif
            end else begin
              cfg_error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            frame_data_o <= in_data;
            row_we_o     <= NumRows'(1) << row_cnt;
            row_cnt      <= row_cnt + 1'b1;
`ifdef FRAME_CHECKSUM_EN
            xor_acc      <= xor_acc ^ in_data;
            if (row_cnt == RowW'(NumRows - 1)) begin
              state <= CHECK;
            end
`else
            if (row_cnt == RowW'(NumRows - 1)) begin
              state    <= STROBE;
              in_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == xor_acc) begin
              state <= STROBE;
            end else begin
              // Rows stay loaded but are never committed.
              cfg_error <= 1'b1;
              state     <= GAP;
            end
          end
        end
`endif
        STROBE: begin
          col_sel_o      <= ColBits'(col_q);
          frame_strobe_o <= MaxFramesPerCol'(1) << frm_q;
          if (frames_done != '1) begin
            frames_done <= frames_done + 1'b1;
          end
          state <= GAP;
        end
        GAP: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb/tb_frame_config_sequencer.sv - directed and random packet bench against a packet-level reference model
module tb_frame_config_sequencer;

  localparam int ROWS = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic        UserCLK;
  logic        resetn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] frame_data_o;
  logic [3:0]  row_we_o;
  logic [7:0]  col_sel_o;
  logic [19:0] frame_strobe_o;
  logic        busy;
  logic        cfg_error;
  logic [15:0] frames_done;

  frame_config_sequencer #(.NumRows(ROWS)) dut (
    .UserCLK        (UserCLK),
    .resetn         (resetn),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .frame_data_o   (frame_data_o),
    .row_we_o       (row_we_o),
    .col_sel_o      (col_sel_o),
    .frame_strobe_o (frame_strobe_o),
    .busy           (busy),
    .cfg_error      (cfg_error),
    .frames_done    (frames_done)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  int tests = 0;
  int fails = 0;

  // Packet-level model: words still owed by the current packet, and the
  // post-packet cooldown during which the sequencer refuses words.
  int          words_left = 0;
  int          row = 0;
  int          block = 0;
  logic [7:0]  m_col = '0;
  logic [7:0]  m_frm = '0;
  logic [31:0] m_xor = '0;
  logic        exp_ready = 1'b0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_row_we = '0;
  logic [19:0] exp_strobe = '0;
  logic [7:0]  exp_col = '0;
  logic        exp_busy = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_done = '0;

  int          strobe_cnt = 0;
  int          rowwe_cnt = 0;
  logic [19:0] last_strobe = '0;
  logic [7:0]  last_col = '0;
  int          low_run = 0;
  int          last_low_run = 0;
  int          exp_strobes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic x, input logic [31:0] d);
    exp_row_we = '0;
    exp_strobe = '0;
    if (rst) begin
      words_left = 0; row = 0; block = 0;
      exp_ready = 1'b0; exp_data = '0; exp_col = '0;
      exp_busy = 1'b0; exp_err = 1'b0; exp_done = '0;
      return;
    end
    if (block > 0) begin
      if (block == 2) begin
        exp_strobe[m_frm] = 1'b1;
        exp_col = m_col;
        if (exp_done != 16'hFFFF) exp_done = exp_done + 16'd1;
      end
      block--;
    end else if (x) begin
      if (words_left == 0) begin
        if (d[31:28] == 4'hA && d[27:20] < 8'd16 && d[19:12] < 8'd20) begin
          m_col = d[27:20]; m_frm = d[19:12];
          words_left = ROWS + CK; row = 0; m_xor = '0;
        end else begin
          exp_err = 1'b1;
        end
      end else if (words_left > CK) begin
        exp_data = d;
        exp_row_we[row] = 1'b1;
        row++;
        m_xor = m_xor ^ d;
        words_left--;
        if (words_left == 0) block = 2;
      end else begin
        words_left = 0;
        if (d == m_xor) block = 2;
        else begin
          block = 1;
          exp_err = 1'b1;
        end
      end
    end
    exp_ready = (block == 0);
    exp_busy = (words_left > 0) || (block > 0);
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, exp_ready);
    chk("frame_data_o", frame_data_o, exp_data);
    chk("row_we_o", row_we_o, exp_row_we);
    chk("frame_strobe_o", frame_strobe_o, exp_strobe);
    chk("col_sel_o", col_sel_o, exp_col);
    chk("busy", busy, exp_busy);
    chk("cfg_error", cfg_error, exp_err);
    chk("frames_done", frames_done, exp_done);
    if (frame_strobe_o !== '0) begin
      strobe_cnt++;
      last_strobe = frame_strobe_o;
      last_col = col_sel_o;
    end
    if (row_we_o !== '0) rowwe_cnt++;
    if (in_ready === 1'b0) low_run++;
    else begin
      if (low_run > 0) last_low_run = low_run;
      low_run = 0;
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [31:0] d);
    logic x;
    resetn = !rst;
    in_valid = v;
    in_data = d;
    x = v && exp_ready && !rst;
    @(posedge UserCLK);
    model_edge(rst, x, d);
    @(negedge UserCLK);
    check_outputs();
  endtask

  task automatic send_word(input logic [31:0] d, input int stall_pct);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      if ($urandom_range(99) < stall_pct) step(1'b0, 1'b0, $urandom);
      else begin
        done = exp_ready;
        step(1'b0, 1'b1, d);
      end
      n++;
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL send_timeout: observed no transfer expected transfer of %0h", d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom);
  endtask

  // Sends header, data and (when enabled) trailer; bad_sum corrupts the trailer.
  task automatic send_packet(input logic [7:0] col, input logic [7:0] frm,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input logic bad_sum, input int stall_pct);
    logic [31:0] w [4];
    logic [31:0] sum;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    sum = '0;
    send_word({4'hA, col, frm, 12'h000}, stall_pct);
    for (int i = 0; i < ROWS; i++) begin
      send_word(w[i], stall_pct);
      sum = sum ^ w[i];
    end
    if (CK == 1) send_word(bad_sum ? (sum ^ 32'h1) : sum, stall_pct);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rw0;
    resetn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    @(negedge UserCLK);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // Basic packet, in_valid held high.
    send_word(32'hA030_5000, 0);
    for (int i = 1; i <= 4; i++) send_word(i, 0);
    if (CK == 1) send_word(32'h4, 0);
    idle(3);
    exp_strobes = 1;
    chk("t1_strobe", last_strobe, 20'h00020);
    chk("t1_col", last_col, 8'd3);
    chk("t1_done", frames_done, 16'd1);
    chk("t1_strobe_cnt", strobe_cnt, exp_strobes);
    chk("t1_rowwe_cnt", rowwe_cnt, ROWS);

    // Bad headers, then a valid packet.
    rw0 = rowwe_cnt;
    send_word(32'hB000_0000, 0);
    send_word(32'hA100_0000, 0);
    send_word(32'hA001_4000, 0);
    idle(2);
    chk("t2_err", cfg_error, 1'b1);
    chk("t2_busy", busy, 1'b0);
    chk("t2_rowwe_cnt", rowwe_cnt, rw0);
    chk("t2_strobe_cnt", strobe_cnt, exp_strobes);
    send_packet(8'd15, 8'd19, $urandom, $urandom, $urandom, $urandom, 1'b0, 0);
    idle(3);
    exp_strobes++;
    chk("t2_commit", strobe_cnt, exp_strobes);
    chk("t2_col", last_col, 8'd15);
    chk("t2_frame", last_strobe, 20'h80000);

    // in_valid toggling through a packet.
    rw0 = rowwe_cnt;
    send_word(32'hA010_2000, 0);
    step(1'b0, 1'b0, $urandom);
    for (int i = 0; i < ROWS + CK; i++) begin
      send_word((i < ROWS) ? 32'(i + 16) : 32'(16 ^ 17 ^ 18 ^ 19), 0);
      step(1'b0, 1'b0, $urandom);
    end
    idle(2);
    exp_strobes++;
    chk("t3_rowwe_cnt", rowwe_cnt, rw0 + ROWS);
    chk("t3_strobe_cnt", strobe_cnt, exp_strobes);

    // Reset after two data words aborts the frame.
    send_word(32'hA050_6000, 0);
    send_word(32'h11, 0);
    send_word(32'h22, 0);
    rw0 = rowwe_cnt;
    step(1'b1, 1'b0, 32'h33);
    idle(6);
    chk("t4_no_rowwe", rowwe_cnt, rw0);
    chk("t4_no_strobe", strobe_cnt, exp_strobes);
    send_packet(8'd5, 8'd6, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 0);
    idle(3);
    exp_strobes++;
    chk("t4_commit", strobe_cnt, exp_strobes);
    chk("t4_done", frames_done, 16'd1);

`ifdef FRAME_CHECKSUM_EN
    send_packet(8'd3, 8'd5, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1, 0);
    idle(3);
    chk("t5_err", cfg_error, 1'b1);
    chk("t5_no_strobe", strobe_cnt, exp_strobes);
    chk("t5_done", frames_done, 16'd1);
`endif

    // Back-to-back packets.
    send_packet(8'd1, 8'd1, $urandom, $urandom, $urandom, $urandom, 1'b0, 0);
    send_packet(8'd2, 8'd2, $urandom, $urandom, $urandom, $urandom, 1'b0, 0);
    chk("t6_gap", last_low_run, 2);
    idle(3);
    exp_strobes += 2;
    chk("t6_strobe_cnt", strobe_cnt, exp_strobes);

    // Random packets with random stalls, bad headers and bad checksums.
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(9) < 8) begin
        send_packet(8'($urandom_range(15)), 8'($urandom_range(19)), $urandom, $urandom,
                    $urandom, $urandom, ($urandom_range(4) == 0), $urandom_range(50));
      end else begin
        send_word($urandom, 0);
        if (words_left > 0) begin
          for (int i = 0; i < ROWS + CK; i++) send_word($urandom, 20);
        end
      end
      idle($urandom_range(2));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
